// File: rtl/tictactoe_pkg.sv
// Shared board-side types: cell count, the "no cell" address, response status codes
// and the write-position decoder FSM states.
package tictactoe_pkg;

    localparam int NCELLS = 9;
    localparam int AW     = 4;

    localparam logic [AW-1:0] ADDR_NONE = 4'hF;

    typedef enum logic [2:0] {
        OK        = 3'd0,
        SUGGESTED = 3'd1,
        BADPOS    = 3'd2,
        OCCUPIED  = 3'd3,
        FULL      = 3'd4
    } status_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SCAN   = 2'd2,
        RESP   = 2'd3
    } wp_state_t;

endpackage

// File: rtl/onehot2addr.sv
// Combinational decode of a board write position into a cell index.
// index is only meaningful when isOneHot is set.
module onehot2addr #(
    parameter int NCELLS = 9,
    parameter int AW     = 4
) (
    input  logic [NCELLS-1:0] writePos,
    output logic [AW-1:0]     index,
    output logic              isOneHot
);

    logic [AW-1:0] idx_terms [NCELLS];

    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_term
        assign idx_terms[gi] = writePos[gi] ? AW'(gi) : '0;
    end

    always_comb begin
        index = '0;
        for (int i = 0; i < NCELLS; i++) begin
            index = index | idx_terms[i];
        end
    end

    // Clearing the lowest set bit leaves zero exactly when one bit was set.
    assign isOneHot = (writePos != '0) && ((writePos & (writePos - NCELLS'(1))) == '0);

endmodule

// File: rtl/writepos2addr_scan.sv
// Maps a one-hot board write position back to a cell address; on a bad or occupied
// request it can walk forward (with wrap) to the next free cell, one cell per clock.
module writepos2addr_scan #(
    parameter int NCELLS = tictactoe_pkg::NCELLS,
    parameter int AW     = tictactoe_pkg::AW
) (
    input  logic              ph2,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [NCELLS-1:0] writePos,
    input  logic [NCELLS-1:0] occupied,
    input  logic              suggest,
    output logic              outValid,
    input  logic              outReady,
    output logic [AW-1:0]     addr,
    output logic [2:0]        status
);

    import tictactoe_pkg::status_t;
    import tictactoe_pkg::wp_state_t;
    import tictactoe_pkg::OK;
    import tictactoe_pkg::SUGGESTED;
    import tictactoe_pkg::BADPOS;
    import tictactoe_pkg::OCCUPIED;
    import tictactoe_pkg::FULL;
    import tictactoe_pkg::IDLE;
    import tictactoe_pkg::DECODE;
    import tictactoe_pkg::SCAN;
    import tictactoe_pkg::RESP;

    localparam logic [AW-1:0] ADDR_NONE = AW'(tictactoe_pkg::ADDR_NONE);
    localparam logic [AW-1:0] LAST_CELL = AW'(NCELLS - 1);

    wp_state_t         state_q, state_d;
    logic [NCELLS-1:0] wp_q, wp_d;
    logic [NCELLS-1:0] occ_q, occ_d;
    logic              sug_q, sug_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     addr_q, addr_d;
    status_t           status_q, status_d;

    logic [AW-1:0]     wp_index;
    logic              wp_one_hot;

    function automatic logic [AW-1:0] next_cell(input logic [AW-1:0] p);
        return (p == LAST_CELL) ? '0 : p + AW'(1);
    endfunction

    onehot2addr #(
        .NCELLS (NCELLS),
        .AW     (AW)
    ) u_decode (
        .writePos (wp_q),
        .index    (wp_index),
        .isOneHot (wp_one_hot)
    );

    assign inReady  = (state_q == IDLE) && !reset;
    assign outValid = out_valid_q;
    assign addr     = addr_q;
    assign status   = status_q;

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        occ_d       = occ_q;
        sug_d       = sug_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        addr_d      = addr_q;
        status_d    = status_q;

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    wp_d    = writePos;
                    occ_d   = occupied;
                    sug_d   = suggest;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                if (&occ_q) begin
                    addr_d   = ADDR_NONE;
                    status_d = FULL;
                    state_d  = RESP;
                end else if (wp_one_hot && !occ_q[wp_index]) begin
                    addr_d   = wp_index;
                    status_d = OK;
                    state_d  = RESP;
                end else begin
                    addr_d   = ADDR_NONE;
                    status_d = wp_one_hot ? OCCUPIED : BADPOS;
                    if (sug_q) begin
                        // An occupied target starts the search just past itself.
                        ptr_d   = wp_one_hot ? next_cell(wp_index) : '0;
                        state_d = SCAN;
                    end else begin
                        state_d = RESP;
                    end
                end
            end

            SCAN: begin
                // Board is known not full here, so this always finds a free cell.
                if (!occ_q[ptr_q]) begin
                    addr_d   = ptr_q;
                    status_d = SUGGESTED;
                    state_d  = RESP;
                end else begin
                    ptr_d = next_cell(ptr_q);
                end
            end

            RESP: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph2) begin
        if (reset) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            occ_q       <= '0;
            sug_q       <= 1'b0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            addr_q      <= ADDR_NONE;
            status_q    <= OK;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            occ_q       <= occ_d;
            sug_q       <= sug_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            addr_q      <= addr_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_writepos2addr_scan.sv
// Bench for writepos2addr_scan: vector table, random vectors against a reference
// model, and hand-written backpressure / reset-during-scan sequences.
module tb_writepos2addr_scan;

    localparam int ST_OK = 0, ST_SUG = 1, ST_BAD = 2, ST_OCC = 3, ST_FULL = 4;

    logic       ph2 = 1'b0;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [8:0] writePos;
    logic [8:0] occupied;
    logic       suggest;
    logic       outValid;
    logic       outReady;
    logic [3:0] addr;
    logic [2:0] status;

    always #5 ph2 = ~ph2;

    writepos2addr_scan dut (
        .ph2      (ph2),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .writePos (writePos),
        .occupied (occupied),
        .suggest  (suggest),
        .outValid (outValid),
        .outReady (outReady),
        .addr     (addr),
        .status   (status)
    );

    typedef struct {
        logic [3:0] addr;
        logic [2:0] status;
        int         lat;
    } exp_t;

    typedef struct {
        logic [8:0] wp;
        logic [8:0] occ;
        logic       sug;
        logic [3:0] addr;
        logic [2:0] status;
        int         lat;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[11];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [8:0] wp, input logic [8:0] occ, input logic sug);
        exp_t e;
        int   idx;
        int   start;
        idx      = -1;
        e.lat    = 2;
        e.addr   = 4'hF;
        if (occ == 9'h1FF) begin
            e.status = 3'(ST_FULL);
            return e;
        end
        if ($countones(wp) == 1) begin
            for (int i = 0; i < 9; i++) if (wp[i]) idx = i;
        end
        if (idx >= 0 && !occ[idx]) begin
            e.addr   = 4'(idx);
            e.status = 3'(ST_OK);
            return e;
        end
        e.status = (idx >= 0) ? 3'(ST_OCC) : 3'(ST_BAD);
        if (sug) begin
            start = (idx >= 0) ? (idx + 1) % 9 : 0;
            for (int i = 0; i < 9; i++) begin
                int c;
                c = (start + i) % 9;
                if (!occ[c]) begin
                    e.addr   = 4'(c);
                    e.status = 3'(ST_SUG);
                    e.lat    = 3 + i;
                    return e;
                end
            end
        end
        return e;
    endfunction

    // Issue one request, then collect its response with outReady held high.
    task automatic run_req(input string tag, input logic [8:0] wp, input logic [8:0] occ,
                           input logic sug, input exp_t e);
        int   lat;
        exp_t got;
        @(negedge ph2);
        check({tag, ".inReady"}, int'(inReady), 1);
        inValid  = 1'b1;
        writePos = wp;
        occupied = occ;
        suggest  = sug;
        outReady = 1'b1;
        sb.push_back(e);
        @(posedge ph2);
        @(negedge ph2);
        inValid  = 1'b0;
        writePos = 9'($urandom);
        occupied = 9'($urandom);
        suggest  = 1'($urandom);
        lat = 0;
        while (!outValid && lat < 30) begin
            @(posedge ph2);
            lat++;
            @(negedge ph2);
        end
        if (!outValid) begin
            check({tag, ".timeout"}, 0, 1);
            sb.delete();
        end else begin
            got = sb.pop_front();
            $display("txn %s wp=%h occ=%h sug=%0d addr=%0d status=%0d lat=%0d",
                     tag, wp, occ, sug, addr, status, lat);
            check({tag, ".addr"}, int'(addr), int'(got.addr));
            check({tag, ".status"}, int'(status), int'(got.status));
            check({tag, ".latency"}, lat, got.lat);
        end
        @(posedge ph2);
        @(negedge ph2);
        check({tag, ".outValid_drop"}, int'(outValid), 0);
        check({tag, ".inReady_back"}, int'(inReady), 1);
    endtask

    initial begin
        int   lat;
        int   seen;
        exp_t e;
        exp_t got;
        logic [8:0] rwp;
        logic [8:0] rocc;
        logic       rsug;

        vecs[0]  = '{9'h010, 9'h000, 1'b0, 4'h4, 3'(ST_OK),   2};
        vecs[1]  = '{9'h000, 9'h003, 1'b1, 4'h2, 3'(ST_SUG),  5};
        vecs[2]  = '{9'h000, 9'h003, 1'b0, 4'hF, 3'(ST_BAD),  2};
        vecs[3]  = '{9'h100, 9'h101, 1'b1, 4'h1, 3'(ST_SUG),  4};
        vecs[4]  = '{9'h001, 9'h1FF, 1'b1, 4'hF, 3'(ST_FULL), 2};
        vecs[5]  = '{9'h003, 9'h000, 1'b1, 4'h0, 3'(ST_SUG),  3};
        vecs[6]  = '{9'h004, 9'h004, 1'b0, 4'hF, 3'(ST_OCC),  2};
        vecs[7]  = '{9'h004, 9'h0FC, 1'b1, 4'h8, 3'(ST_SUG),  8};
        vecs[8]  = '{9'h100, 9'h000, 1'b0, 4'h8, 3'(ST_OK),   2};
        vecs[9]  = '{9'h080, 9'h1FE, 1'b1, 4'h0, 3'(ST_SUG),  4};
        vecs[10] = '{9'h000, 9'h0FF, 1'b1, 4'h8, 3'(ST_SUG),  11};

        reset    = 1'b1;
        inValid  = 1'b0;
        writePos = '0;
        occupied = '0;
        suggest  = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge ph2);
        @(negedge ph2);
        check("reset.outValid", int'(outValid), 0);
        check("reset.addr", int'(addr), 15);
        check("reset.status", int'(status), ST_OK);
        check("reset.inReady", int'(inReady), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            e.addr   = vecs[i].addr;
            e.status = vecs[i].status;
            e.lat    = vecs[i].lat;
            run_req($sformatf("vec%0d", i), vecs[i].wp, vecs[i].occ, vecs[i].sug, e);
        end

        for (int i = 0; i < 20; i++) begin
            rwp  = ($urandom_range(0, 2) != 0) ? (9'h001 << $urandom_range(0, 8)) : 9'($urandom);
            rocc = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
            rsug = 1'($urandom);
            run_req($sformatf("rnd%0d", i), rwp, rocc, rsug, model(rwp, rocc, rsug));
        end

        // Backpressure: response must hold while outReady is low and inValid is ignored.
        @(negedge ph2);
        inValid  = 1'b1;
        writePos = 9'h010;
        occupied = 9'h000;
        suggest  = 1'b0;
        outReady = 1'b0;
        sb.push_back(model(9'h010, 9'h000, 1'b0));
        @(posedge ph2);
        @(negedge ph2);
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 30) begin
            @(posedge ph2);
            lat++;
            @(negedge ph2);
        end
        got = sb.pop_front();
        $display("txn bp wp=010 occ=000 sug=0 addr=%0d status=%0d lat=%0d", addr, status, lat);
        check("bp.latency", lat, got.lat);
        for (int c = 0; c < 5; c++) begin
            inValid  = 1'b1;
            writePos = 9'h001;
            occupied = 9'h000;
            @(posedge ph2);
            @(negedge ph2);
            check($sformatf("bp%0d.outValid", c), int'(outValid), 1);
            check($sformatf("bp%0d.addr", c), int'(addr), int'(got.addr));
            check($sformatf("bp%0d.status", c), int'(status), int'(got.status));
            check($sformatf("bp%0d.inReady", c), int'(inReady), 0);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge ph2);
        @(negedge ph2);
        check("bp.release.outValid", int'(outValid), 0);
        check("bp.release.inReady", int'(inReady), 1);
        seen = 0;
        repeat (4) begin
            @(posedge ph2);
            @(negedge ph2);
            if (outValid) seen++;
        end
        check("bp.no_stray_response", seen, 0);

        // Reset while the search is still walking the board.
        @(negedge ph2);
        inValid  = 1'b1;
        writePos = 9'h000;
        occupied = 9'h0FF;
        suggest  = 1'b1;
        @(posedge ph2);
        @(negedge ph2);
        inValid = 1'b0;
        repeat (4) @(posedge ph2);
        @(negedge ph2);
        reset = 1'b1;
        @(posedge ph2);
        @(negedge ph2);
        $display("txn rst_scan outValid=%0d addr=%0d status=%0d", outValid, addr, status);
        check("rst_scan.outValid", int'(outValid), 0);
        check("rst_scan.addr", int'(addr), 15);
        check("rst_scan.status", int'(status), ST_OK);
        check("rst_scan.inReady", int'(inReady), 0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge ph2);
            @(negedge ph2);
            if (outValid) seen++;
        end
        check("rst_scan.no_response", seen, 0);

        e.addr   = 4'h1;
        e.status = 3'(ST_SUG);
        e.lat    = 4;
        run_req("after_rst", 9'h100, 9'h101, 1'b1, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
